// File: rtl/in_frame_ctrl.sv
// Input frame sequencer: hunts for SYNC, takes LEN, streams the payload through with
// zero latency, checks the trailing checksum and reports per-frame status and counts.
module in_frame_ctrl #(
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_a,
  input  logic             ena,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             frm_done,
  output logic             frm_ok,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned      TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [7:0]       MAX_B    = 8'(MAX_LEN);

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CHK  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  typedef enum logic [1:0] {HUNT, LEN, PAY, CHK} state_t;

  state_t             state, state_nx;
  logic [7:0]         remaining, rem_nx;
  logic [7:0]         sum, sum_nx;
  logic [7:0]         chk_sum;
  logic [TMO_W-1:0]   tmo_cnt, tmo_nx;
  logic               done_nx, frm_ok_nx;
  logic [1:0]         code_nx;
  logic [CNT_W-1:0]   ok_cnt_nx, err_cnt_nx;
  logic               accept, pass, fail;
  logic [1:0]         fail_code;

  assign chk_sum = sum + in_data;

  // Next-state, handshake and status decode
  always_comb begin
    state_nx   = state;
    rem_nx     = remaining;
    sum_nx     = sum;
    tmo_nx     = tmo_cnt;
    done_nx    = 1'b0;
    frm_ok_nx  = frm_ok;
    code_nx    = err_code;
    ok_cnt_nx  = ok_cnt;
    err_cnt_nx = err_cnt;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_data   = in_data;
    accept     = 1'b0;
    pass       = 1'b0;
    fail       = 1'b0;
    fail_code  = ERR_NONE;

    case (state)
      HUNT: begin
        in_ready = ena;
        accept   = ena & in_valid;
        if (accept && in_data == SYNC) state_nx = LEN;
      end
      LEN: begin
        in_ready = ena;
        accept   = ena & in_valid;
        if (accept) begin
          if (in_data == 8'd0 || in_data > MAX_B) begin
            fail      = 1'b1;
            fail_code = ERR_LEN;
          end else begin
            rem_nx   = in_data;
            sum_nx   = in_data;
            state_nx = PAY;
          end
        end
      end
      PAY: begin
        in_ready  = ena & out_ready;
        out_valid = ena & in_valid;
        out_last  = (remaining == 8'd1);
        accept    = ena & in_valid & out_ready;
        if (accept) begin
          sum_nx = chk_sum;
          rem_nx = remaining - 8'd1;
          if (remaining == 8'd1) state_nx = CHK;
        end
      end
      CHK: begin
        in_ready = ena;
        accept   = ena & in_valid;
        if (accept) begin
          if (chk_sum == 8'd0) begin
            pass = 1'b1;
          end else begin
            fail      = 1'b1;
            fail_code = ERR_CHK;
          end
        end
      end
      default: state_nx = HUNT;
    endcase

    // Starvation watchdog: only source-idle cycles while enabled advance it
    if (state != HUNT) begin
      if (accept) begin
        tmo_nx = '0;
      end else if (ena && !in_valid && TIMEOUT != 0) begin
        if (tmo_cnt == TMO_LAST) begin
          fail      = 1'b1;
          fail_code = ERR_TMO;
        end else begin
          tmo_nx = tmo_cnt + TMO_W'(1);
        end
      end
    end

    if (pass) begin
      state_nx  = HUNT;
      tmo_nx    = '0;
      done_nx   = 1'b1;
      frm_ok_nx = 1'b1;
      code_nx   = ERR_NONE;
      ok_cnt_nx = ok_cnt + CNT_W'(1);
    end
    if (fail) begin
      state_nx   = HUNT;
      tmo_nx     = '0;
      done_nx    = 1'b1;
      frm_ok_nx  = 1'b0;
      code_nx    = fail_code;
      err_cnt_nx = err_cnt + CNT_W'(1);
    end
  end

  // State and status registers
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state     <= HUNT;
      remaining <= '0;
      sum       <= '0;
      tmo_cnt   <= '0;
      frm_done  <= 1'b0;
      frm_ok    <= 1'b0;
      err_code  <= ERR_NONE;
      ok_cnt    <= '0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nx;
      remaining <= rem_nx;
      sum       <= sum_nx;
      tmo_cnt   <= tmo_nx;
      frm_done  <= done_nx;
      frm_ok    <= frm_ok_nx;
      err_code  <= code_nx;
      ok_cnt    <= ok_cnt_nx;
      err_cnt   <= err_cnt_nx;
    end
  end

endmodule

// File: tb/tb_in_frame_ctrl.sv
// Directed bench for in_frame_ctrl: frames, errors, backpressure, timeout, enable freeze
// and mid-frame reset, each scenario checking its own hand-computed results.
module tb_in_frame_ctrl;
  logic        clk = 1'b0;
  logic        rst_a, ena, in_valid, in_ready, out_valid, out_ready, out_last;
  logic        frm_done, frm_ok;
  logic [7:0]  in_data, out_data;
  logic [1:0]  err_code;
  logic [15:0] ok_cnt, err_cnt;

  int n_chk = 0, n_pass = 0, exp_ok = 0, exp_err = 0, done_seen = 0;
  logic [7:0] q_data[$];
  logic       q_last[$];

  in_frame_ctrl #(.SYNC(8'hA5), .MAX_LEN(64), .TIMEOUT(8), .CNT_W(16)) dut (
    .clk(clk), .rst_a(rst_a), .ena(ena), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .frm_done(frm_done), .frm_ok(frm_ok), .err_code(err_code),
    .ok_cnt(ok_cnt), .err_cnt(err_cnt));

  always #5 clk = ~clk;

  // Capture downstream handshakes and status pulses
  always @(posedge clk) begin
    if (out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_last.push_back(out_last);
    end
    if (frm_done) done_seen++;
  end

  task automatic send(input logic [7:0] b);
    int w = 0;
    in_data = b; in_valid = 1'b1; #1;
    while (!in_ready && w < 200) begin @(negedge clk); #1; w++; end
    if (!in_ready) begin
      n_chk++; $display("FAIL send_accept: byte %h not accepted within 200 cycles", b);
    end else @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk); #1;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
    n_chk++; if (out_last !== 1'b0) $display("FAIL rst_out_last: got %b want 0", out_last); else n_pass++;
    n_chk++; if (frm_done !== 1'b0) $display("FAIL rst_frm_done: got %b want 0", frm_done); else n_pass++;
    n_chk++; if (frm_ok !== 1'b0) $display("FAIL rst_frm_ok: got %b want 0", frm_ok); else n_pass++;
    n_chk++; if (err_code !== 2'd0) $display("FAIL rst_err_code: got %0d want 0", err_code); else n_pass++;
    n_chk++; if (ok_cnt !== 16'd0) $display("FAIL rst_ok_cnt: got %0d want 0", ok_cnt); else n_pass++;
    n_chk++; if (err_cnt !== 16'd0) $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); else n_pass++;
    rst_a = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_good_frame;
    logic [7:0] fr[] = '{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h9D};
    logic [7:0] exp_d[] = '{8'h10, 8'h20, 8'h30};
    q_data.delete(); q_last.delete();
    foreach (fr[i]) send(fr[i]);
    exp_ok++;
    n_chk++; if (frm_done !== 1'b1) $display("FAIL good_done: got %b want 1", frm_done); else n_pass++;
    n_chk++; if (frm_ok !== 1'b1) $display("FAIL good_ok: got %b want 1", frm_ok); else n_pass++;
    n_chk++; if (err_code !== 2'd0) $display("FAIL good_code: got %0d want 0", err_code); else n_pass++;
    n_chk++; if (ok_cnt !== 16'(exp_ok)) $display("FAIL good_ok_cnt: got %0d want %0d", ok_cnt, exp_ok); else n_pass++;
    n_chk++; if (q_data.size() != 3) $display("FAIL good_len: got %0d want 3", q_data.size()); else n_pass++;
    foreach (exp_d[i]) begin
      n_chk++;
      if (i >= q_data.size() || q_data[i] !== exp_d[i] || q_last[i] !== (i == 2))
        $display("FAIL good_byte%0d: got %h want %h/last %0d", i, (i < q_data.size()) ? q_data[i] : 8'hxx, exp_d[i], i == 2);
      else n_pass++;
    end
    @(negedge clk);
    n_chk++; if (frm_done !== 1'b0) $display("FAIL good_pulse_width: got %b want 0", frm_done); else n_pass++;
  endtask

  task automatic test_bad_checksum;
    logic [7:0] fr[] = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h00};
    q_data.delete(); q_last.delete();
    foreach (fr[i]) send(fr[i]);
    exp_err++;
    n_chk++; if (frm_done !== 1'b1) $display("FAIL chk_done: got %b want 1", frm_done); else n_pass++;
    n_chk++; if (frm_ok !== 1'b0) $display("FAIL chk_ok: got %b want 0", frm_ok); else n_pass++;
    n_chk++; if (err_code !== 2'd2) $display("FAIL chk_code: got %0d want 2", err_code); else n_pass++;
    n_chk++; if (err_cnt !== 16'(exp_err)) $display("FAIL chk_err_cnt: got %0d want %0d", err_cnt, exp_err); else n_pass++;
    n_chk++;
    if (q_data.size() != 2 || q_data[0] !== 8'h01 || q_data[1] !== 8'h02 || q_last[1] !== 1'b1)
      $display("FAIL chk_payload: got %0d bytes want 01,02 with last", q_data.size());
    else n_pass++;
  endtask

  task automatic test_bad_length;
    logic [7:0] lens[] = '{8'h00, 8'h41, 8'hA5};
    logic [7:0] fr[] = '{8'h02, 8'hA5, 8'h01, 8'h05, 8'hFA};
    q_data.delete(); q_last.delete();
    foreach (lens[i]) begin
      send(8'hA5); send(lens[i]);
      exp_err++;
      n_chk++;
      if (frm_done !== 1'b1 || err_code !== 2'd1 || frm_ok !== 1'b0)
        $display("FAIL len_%h: got done %b code %0d ok %b want 1 1 0", lens[i], frm_done, err_code, frm_ok);
      else n_pass++;
    end
    n_chk++; if (err_cnt !== 16'(exp_err)) $display("FAIL len_err_cnt: got %0d want %0d", err_cnt, exp_err); else n_pass++;
    n_chk++; if (q_data.size() != 0) $display("FAIL len_no_out: got %0d bytes want 0", q_data.size()); else n_pass++;
    foreach (fr[i]) send(fr[i]);
    exp_ok++;
    n_chk++;
    if (frm_ok !== 1'b1 || ok_cnt !== 16'(exp_ok) || q_data.size() != 1 || q_data[0] !== 8'h05)
      $display("FAIL len_recover: got ok %b ok_cnt %0d bytes %0d want 1 %0d 1", frm_ok, ok_cnt, q_data.size(), exp_ok);
    else n_pass++;
  endtask

  task automatic test_max_len;
    int lasts = 0;
    q_data.delete(); q_last.delete();
    send(8'hA5); send(8'h40);
    repeat (64) send(8'h01);
    send(8'h80);
    exp_ok++;
    foreach (q_last[i]) if (q_last[i]) lasts++;
    n_chk++; if (frm_ok !== 1'b1 || err_code !== 2'd0) $display("FAIL max_status: got ok %b code %0d want 1 0", frm_ok, err_code); else n_pass++;
    n_chk++; if (q_data.size() != 64) $display("FAIL max_len: got %0d want 64", q_data.size()); else n_pass++;
    n_chk++;
    if (lasts != 1 || q_last.size() != 64 || q_last[63] !== 1'b1) $display("FAIL max_last: got %0d lasts want 1 on byte 63", lasts);
    else n_pass++;
  endtask

  task automatic test_junk_sync;
    logic [7:0] fr[] = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7F, 8'h80, 8'hA5, 8'h02, 8'hA5, 8'hA5, 8'hB4};
    q_data.delete(); q_last.delete();
    foreach (fr[i]) begin
      send(fr[i]);
      if (i == 5) begin
        exp_ok++;
        n_chk++;
        if (frm_done !== 1'b1 || frm_ok !== 1'b1 || q_data.size() != 1 || q_data[0] !== 8'h7F || q_last[0] !== 1'b1)
          $display("FAIL junk_frame: got done %b ok %b bytes %0d want 1 1 1 (7F last)", frm_done, frm_ok, q_data.size());
        else n_pass++;
      end
    end
    exp_ok++;
    n_chk++;
    if (frm_ok !== 1'b1 || q_data.size() != 3 || q_data[1] !== 8'hA5 || q_data[2] !== 8'hA5)
      $display("FAIL sync_as_data: got ok %b bytes %0d want 1 3", frm_ok, q_data.size());
    else n_pass++;
    n_chk++; if (ok_cnt !== 16'(exp_ok)) $display("FAIL junk_ok_cnt: got %0d want %0d", ok_cnt, exp_ok); else n_pass++;
  endtask

  task automatic test_backpressure_timeout;
    int d0;
    logic [7:0] fr[] = '{8'h11, 8'h22, 8'h33, 8'h97};
    q_data.delete(); q_last.delete();
    send(8'hA5); send(8'h03);
    d0 = done_seen;
    in_data = 8'h11; in_valid = 1'b1; out_ready = 1'b0; #1;
    n_chk++; if (in_ready !== 1'b0 || out_valid !== 1'b1) $display("FAIL bp_handshake: got ready %b valid %b want 0 1", in_ready, out_valid); else n_pass++;
    repeat (50) @(negedge clk);
    n_chk++; if (done_seen != d0) $display("FAIL bp_no_abort: got %0d pulses want 0", done_seen - d0); else n_pass++;
    out_ready = 1'b1;
    foreach (fr[i]) send(fr[i]);
    exp_ok++;
    n_chk++; if (frm_ok !== 1'b1 || ok_cnt !== 16'(exp_ok) || q_data.size() != 3) $display("FAIL bp_frame: got ok %b ok_cnt %0d want 1 %0d", frm_ok, ok_cnt, exp_ok); else n_pass++;
    q_data.delete(); q_last.delete();
    send(8'hA5); send(8'h03);
    repeat (7) @(negedge clk);
    n_chk++; if (frm_done !== 1'b0) $display("FAIL tmo_early: got %b after 7 idle want 0", frm_done); else n_pass++;
    @(negedge clk);
    exp_err++;
    n_chk++;
    if (frm_done !== 1'b1 || err_code !== 2'd3 || frm_ok !== 1'b0) $display("FAIL tmo_abort: got done %b code %0d ok %b want 1 3 0", frm_done, err_code, frm_ok);
    else n_pass++;
    n_chk++; if (err_cnt !== 16'(exp_err)) $display("FAIL tmo_err_cnt: got %0d want %0d", err_cnt, exp_err); else n_pass++;
    in_data = 8'h55; in_valid = 1'b1; #1;
    n_chk++; if (out_valid !== 1'b0 || q_data.size() != 0) $display("FAIL tmo_hunt: got out_valid %b bytes %0d want 0 0", out_valid, q_data.size()); else n_pass++;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int d0;
    logic [7:0] fr[] = '{8'hA5, 8'h01, 8'h7F, 8'h80};
    send(8'hA5); send(8'h02); send(8'h10);
    in_data = 8'h20; in_valid = 1'b1; #1;
    n_chk++; if (out_valid !== 1'b1 || out_last !== 1'b1) $display("FAIL rmid_pre: got valid %b last %b want 1 1", out_valid, out_last); else n_pass++;
    d0 = done_seen;
    rst_a = 1'b0; #1;
    n_chk++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || frm_done !== 1'b0 || err_code !== 2'd0 || ok_cnt !== 16'd0 || err_cnt !== 16'd0)
      $display("FAIL rmid_values: got valid %b last %b done %b code %0d ok %0d err %0d want all 0", out_valid, out_last, frm_done, err_code, ok_cnt, err_cnt);
    else n_pass++;
    exp_ok = 0; exp_err = 0;
    @(negedge clk); rst_a = 1'b1; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (done_seen != d0) $display("FAIL rmid_no_done: got %0d pulses want 0", done_seen - d0); else n_pass++;
    q_data.delete(); q_last.delete();
    foreach (fr[i]) send(fr[i]);
    exp_ok++;
    n_chk++;
    if (frm_ok !== 1'b1 || ok_cnt !== 16'(exp_ok) || err_cnt !== 16'd0 || q_data.size() != 1)
      $display("FAIL rmid_next: got ok %b ok_cnt %0d err_cnt %0d want 1 %0d 0", frm_ok, ok_cnt, err_cnt, exp_ok);
    else n_pass++;
  endtask

  task automatic test_ena_freeze;
    int d0;
    send(8'hA5); send(8'h02); send(8'h10);
    d0 = done_seen;
    ena = 1'b0;
    repeat (20) @(negedge clk);
    in_data = 8'h20; in_valid = 1'b1; #1;
    n_chk++; if (in_ready !== 1'b0 || out_valid !== 1'b0) $display("FAIL ena_gate: got ready %b valid %b want 0 0", in_ready, out_valid); else n_pass++;
    @(negedge clk);
    in_valid = 1'b0; ena = 1'b1;
    repeat (5) @(negedge clk);
    n_chk++; if (done_seen != d0) $display("FAIL ena_no_tmo: got %0d pulses want 0", done_seen - d0); else n_pass++;
    send(8'h20); send(8'hCE);
    exp_ok++;
    n_chk++;
    if (frm_done !== 1'b1 || frm_ok !== 1'b1 || ok_cnt !== 16'(exp_ok)) $display("FAIL ena_resume: got done %b ok %b ok_cnt %0d want 1 1 %0d", frm_done, frm_ok, ok_cnt, exp_ok);
    else n_pass++;
  endtask

  initial begin
    rst_a = 1'b0; ena = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_bad_length();
    test_max_len();
    test_junk_sync();
    test_backpressure_timeout();
    test_reset_mid();
    test_ena_freeze();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
